// File: rtl/pipeline_stall_controller.sv
// Pipeline stall/flush controller.
// Turns hazard stall requests and resolved taken branches into the PC / IF/ID
// enables and the flush strobes of a classic 5-stage pipeline. It also keeps
// saturating stall/redirect statistics and a sticky stall-length watchdog.
module pipeline_stall_controller #(
  parameter int unsigned MAX_STALL = 15,  // watchdog threshold, 1..255
  parameter int unsigned PC_W      = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_req,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  output logic            pc_write,
  output logic            if_id_write,
  output logic            if_id_flush,
  output logic            id_ex_flush,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc,
  output logic [15:0]     stall_cycles,
  output logic [15:0]     flush_events,
  output logic            stall_timeout
);

  localparam logic [7:0] MAX_STALL_L = 8'(MAX_STALL);

  typedef enum logic [1:0] {
    S_RUN,
    S_STALL,
    S_FLUSH
  } state_e;

  typedef enum logic [1:0] {
    A_PASS,
    A_HOLD,
    A_REDIRECT
  } action_e;

  state_e      state_q, state_d;
  action_e     action;
  logic [7:0]  stall_len_q, stall_len_d;
  logic [15:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] flush_events_q, flush_events_d;
  logic        stall_timeout_q, stall_timeout_d;

  // Choose this cycle's action; FLUSH ignores wrong-path stall/branch requests.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave
    // it unassigned and infer a latch.
    action = A_PASS;
    if (state_q != S_FLUSH) begin
      if (branch_taken) begin
        action = A_REDIRECT;
      end else if (stall_req) begin
        action = A_HOLD;
      end
    end
  end

  // Pipeline control strobes; reset forces a flushed, frozen pipeline.
  always_comb begin
    pc_write       = 1'b1;
    if_id_write    = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_flush    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (action)
      A_REDIRECT: begin
        redirect_valid = 1'b1;
        redirect_pc    = branch_target;
        if_id_flush    = 1'b1;
        id_ex_flush    = 1'b1;
      end
      A_HOLD: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
      end
      default: ;
    endcase
    if (!rst_n) begin
      pc_write       = 1'b0;
      if_id_write    = 1'b0;
      if_id_flush    = 1'b1;
      id_ex_flush    = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
    end
  end

  // Next state, stall length, statistics and watchdog.
  always_comb begin
    state_d         = S_RUN;
    stall_len_d     = 8'd0;
    stall_cycles_d  = stall_cycles_q;
    flush_events_d  = flush_events_q;
    stall_timeout_d = stall_timeout_q;
    case (action)
      A_REDIRECT: begin
        state_d = S_FLUSH;
        if (flush_events_q != 16'hFFFF) begin
          flush_events_d = flush_events_q + 16'd1;
        end
      end
      A_HOLD: begin
        state_d = S_STALL;
        if (state_q == S_RUN) begin
          stall_len_d = 8'd1;
        end else if (stall_len_q != 8'hFF) begin
          stall_len_d = stall_len_q + 8'd1;
        end else begin
          stall_len_d = stall_len_q;
        end
        if (stall_cycles_q != 16'hFFFF) begin
          stall_cycles_d = stall_cycles_q + 16'd1;
        end
        // The watchdog trips on the edge that completes the MAX_STALL-th hold.
        if (stall_len_d == MAX_STALL_L) begin
          stall_timeout_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // State and statistics registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // sample the same pre-edge values.
    if (!rst_n) begin
      state_q         <= S_RUN;
      stall_len_q     <= 8'd0;
      stall_cycles_q  <= 16'd0;
      flush_events_q  <= 16'd0;
      stall_timeout_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      stall_len_q     <= stall_len_d;
      stall_cycles_q  <= stall_cycles_d;
      flush_events_q  <= flush_events_d;
      stall_timeout_q <= stall_timeout_d;
    end
  end

  assign stall_cycles  = stall_cycles_q;
  assign flush_events  = flush_events_q;
  assign stall_timeout = stall_timeout_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Self-checking bench for pipeline_stall_controller: directed scenarios,
// randomized traffic and a long saturation stall, all checked against a
// cycle-level behavioural model of the controller.
module tb_pipeline_stall_controller;

  localparam int MAX_STALL = 15;
  localparam int PC_W      = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            stall_req;
  logic            branch_taken;
  logic [PC_W-1:0] branch_target;
  logic            pc_write;
  logic            if_id_write;
  logic            if_id_flush;
  logic            id_ex_flush;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic [15:0]     stall_cycles;
  logic [15:0]     flush_events;
  logic            stall_timeout;

  pipeline_stall_controller #(
    .MAX_STALL(MAX_STALL),
    .PC_W     (PC_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_req     (stall_req),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc_write      (pc_write),
    .if_id_write   (if_id_write),
    .if_id_flush   (if_id_flush),
    .id_ex_flush   (id_ex_flush),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .stall_cycles  (stall_cycles),
    .flush_events  (flush_events),
    .stall_timeout (stall_timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: plain integers describing pipeline history.
  bit m_after_redirect;  // previous cycle redirected, so this one is a bubble cycle
  int m_hold_run;        // consecutive hold cycles so far in the current stall
  int m_stall_cnt;
  int m_flush_cnt;
  bit m_timeout;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_reset();
    m_after_redirect = 1'b0;
    m_hold_run       = 0;
    m_stall_cnt      = 0;
    m_flush_cnt      = 0;
    m_timeout        = 1'b0;
  endtask

  // One clock cycle: drive inputs, check combinational outputs mid-cycle,
  // advance the model at the edge, then check registered outputs.
  task automatic cycle(input logic rst, input logic stall, input logic br,
                       input logic [31:0] tgt);
    bit e_pcw, e_ifw, e_iff, e_idf, e_rv;
    logic [31:0] e_rpc;
    bit do_redirect, do_hold;
    rst_n         = rst;
    stall_req     = stall;
    branch_taken  = br;
    branch_target = tgt;
    do_redirect = rst && !m_after_redirect && br;
    do_hold     = rst && !m_after_redirect && !br && stall;
    if (!rst) begin
      {e_pcw, e_ifw, e_iff, e_idf, e_rv} = 5'b00110;
      e_rpc = 0;
    end else if (do_redirect) begin
      {e_pcw, e_ifw, e_iff, e_idf, e_rv} = 5'b11111;
      e_rpc = tgt;
    end else if (do_hold) begin
      {e_pcw, e_ifw, e_iff, e_idf, e_rv} = 5'b00010;
      e_rpc = 0;
    end else begin
      {e_pcw, e_ifw, e_iff, e_idf, e_rv} = 5'b11000;
      e_rpc = 0;
    end
    @(negedge clk);
    check("pc_write",       32'(pc_write),       32'(e_pcw));
    check("if_id_write",    32'(if_id_write),    32'(e_ifw));
    check("if_id_flush",    32'(if_id_flush),    32'(e_iff));
    check("id_ex_flush",    32'(id_ex_flush),    32'(e_idf));
    check("redirect_valid", 32'(redirect_valid), 32'(e_rv));
    check("redirect_pc",    redirect_pc,         e_rpc);
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else if (do_redirect) begin
      m_after_redirect = 1'b1;
      m_hold_run       = 0;
      if (m_flush_cnt < 65535) m_flush_cnt++;
    end else if (do_hold) begin
      m_after_redirect = 1'b0;
      if (m_hold_run < 255) m_hold_run++;
      if (m_stall_cnt < 65535) m_stall_cnt++;
      if (m_hold_run == MAX_STALL) m_timeout = 1'b1;
    end else begin
      m_after_redirect = 1'b0;
      m_hold_run       = 0;
    end
    #1;
    check("stall_cycles",  32'(stall_cycles),  32'(m_stall_cnt));
    check("flush_events",  32'(flush_events),  32'(m_flush_cnt));
    check("stall_timeout", 32'(stall_timeout), 32'(m_timeout));
  endtask

  int burst;

  initial begin
    rst_n         = 1'b0;
    stall_req     = 1'b0;
    branch_taken  = 1'b0;
    branch_target = '0;
    @(posedge clk);
    #1;
    model_reset();

    // Reset state, then a one-cycle stall followed by PASS.
    cycle(0, 1, 1, 32'hDEAD_BEEF);
    cycle(1, 1, 0, 0);
    cycle(1, 0, 0, 0);
    check("single_stall_count", 32'(stall_cycles), 32'd1);

    // Branch wins over a simultaneous stall.
    cycle(1, 1, 1, 32'h0000_0100);
    cycle(1, 0, 0, 0);
    check("redirect_count", 32'(flush_events), 32'd1);

    // Back-to-back branches: the second lands in the bubble cycle.
    cycle(0, 0, 0, 0);
    cycle(1, 0, 1, 32'h0000_2000);
    cycle(1, 1, 1, 32'h0000_3000);
    cycle(1, 0, 0, 0);
    check("b2b_redirect_count", 32'(flush_events), 32'd1);

    // Twenty-cycle stall trips the watchdog after the fifteenth hold.
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 20; i++) cycle(1, 1, 0, 0);
    check("long_stall_count", 32'(stall_cycles), 32'd20);
    check("long_stall_timeout", 32'(stall_timeout), 32'd1);
    cycle(1, 0, 0, 0);

    // Reset in the middle of a five-cycle stall.
    cycle(1, 1, 0, 0);
    cycle(1, 1, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(1, 1, 0, 0);
    cycle(1, 1, 0, 0);
    cycle(1, 0, 0, 0);
    check("mid_stall_reset_count", 32'(stall_cycles), 32'd2);

    // Randomized traffic with occasional long stall bursts and resets.
    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      logic s, b, r;
      if (burst == 0 && $urandom_range(0, 149) == 0) burst = $urandom_range(12, 40);
      if (burst > 0) begin
        s = 1'b1;
        b = 1'b0;
        burst--;
      end else begin
        s = ($urandom_range(0, 9) < 3);
        b = ($urandom_range(0, 99) < 12);
      end
      r = ($urandom_range(0, 199) != 0);
      cycle(r, s, b, $urandom);
    end

    // Saturation of the stall counter across a very long stall.
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 65540; i++) cycle(1, 1, 0, 0);
    check("stall_cycles_saturated", 32'(stall_cycles), 32'hFFFF);
    cycle(1, 0, 1, 32'h0000_0040);
    cycle(1, 0, 0, 0);
    check("stall_cycles_held", 32'(stall_cycles), 32'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
